// File: rtl/vga_line_fetch_pkg.sv
// vga_line_fetch_pkg: shared VGA timing constants, line lengths and the
// line-fetch FSM encoding used by the framebuffer fetch path.
package vga_line_fetch_pkg;
    localparam int H640_ACTIVE   = 640;
    localparam int H640_TOTAL    = 800;
    localparam int V640_ACTIVE   = 480;
    localparam int V640_TOTAL    = 525;
    localparam int H1024_ACTIVE  = 1024;
    localparam int H1024_TOTAL   = 1344;
    localparam int V1024_ACTIVE  = 768;
    localparam int V1024_TOTAL   = 806;
    localparam int LINE_LEN_640  = 640;
    localparam int LINE_LEN_1024 = 1024;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } fetch_state_t;
    // line * LEN using only shifts: 640 = 512 + 128, 1024 = 1 << 10
    function automatic logic [31:0] line_offset(input logic [9:0] line, input logic mode);
        logic [31:0] l;
        l = {22'd0, line};
        return mode ? (l << 10) : (l << 9) + (l << 7);
    endfunction
endpackage

// File: rtl/vga_line_fetch_sync2.sv
// sync2: two-flop synchronizer for a single level signal crossing into i_clk.
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end
    assign o_q = r_q;
endmodule

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: fetches one display line from the framebuffer in bursts
// and writes it into line buffer A or B on request from the display domain.
module vga_line_fetch
    import vga_line_fetch_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 24
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              vga_mode,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              read_buffA_req,
    input  logic              read_buffB_req,
    input  logic [9:0]        read_buff_addr,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [15:0]       mem_rd_data,
    output logic              buffA_wr_en,
    output logic              buffB_wr_en,
    output logic [9:0]        buff_wr_addr,
    output logic [15:0]       buff_wr_data,
    output logic              busy,
    output logic              overrun
);
    localparam int BL_W = $clog2(BURST_LEN);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [1:0]        r_warm;
    logic              r_prev_a;
    logic              r_prev_b;
    logic              r_sel_b;
    logic              r_long;
    logic [ADDR_W-1:0] r_base;
    logic [10:0]       r_cnt;
    logic              w_sync_a;
    logic              w_sync_b;
    logic              w_ready;
    logic              w_trig_a;
    logic              w_trig_b;
    logic              w_busy;
    logic              w_start;
    logic              w_wr;
    logic              w_burst_end;
    logic [10:0]       w_cnt_nxt;
    logic [10:0]       w_len;

    sync2 u_sync_a (.i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_d(read_buffA_req), .o_q(w_sync_a));
    sync2 u_sync_b (.i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_d(read_buffB_req), .o_q(w_sync_b));

    // Edge detection is held off until the synchronizers have refilled after
    // reset, so a request already high at release is not seen as a new edge.
    assign w_ready     = r_warm[1];
    assign w_trig_a    = w_ready & w_sync_a & ~r_prev_a;
    assign w_trig_b    = w_ready & w_sync_b & ~r_prev_b;
    assign w_busy      = r_state != ST_IDLE;
    assign w_start     = ~w_busy & (w_trig_a | w_trig_b);
    assign w_wr        = (r_state == ST_DATA) & mem_rd_valid;
    assign w_cnt_nxt   = r_cnt + 11'd1;
    assign w_len       = r_long ? 11'(LINE_LEN_1024) : 11'(LINE_LEN_640);
    assign w_burst_end = w_wr & (&r_cnt[BL_W-1:0]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_start ? ST_REQ : ST_IDLE;
            ST_REQ:  w_state_nxt = mem_rd_ack ? ST_DATA : ST_REQ;
            ST_DATA: w_state_nxt = !w_burst_end ? ST_DATA : (w_cnt_nxt == w_len) ? ST_IDLE : ST_REQ;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_warm   <= 2'd0;
            r_prev_a <= 1'b1;
            r_prev_b <= 1'b1;
            r_sel_b  <= 1'b0;
            r_long   <= 1'b0;
            r_base   <= '0;
            r_cnt    <= '0;
        end else begin
            if (!w_ready) r_warm <= r_warm + 2'd1;
            r_prev_a <= w_ready ? w_sync_a : 1'b1;
            r_prev_b <= w_ready ? w_sync_b : 1'b1;
            if (w_start) begin
                r_sel_b <= ~w_trig_a;
                r_long  <= vga_mode;
                r_base  <= fb_base + ADDR_W'(line_offset(read_buff_addr, vga_mode));
                r_cnt   <= '0;
            end else if (w_wr) begin
                r_cnt   <= w_cnt_nxt;
            end
        end
    end

    assign mem_rd_req   = r_state == ST_REQ;
    assign mem_rd_addr  = mem_rd_req ? r_base + ADDR_W'(r_cnt) : '0;
    assign buffA_wr_en  = w_wr & ~r_sel_b;
    assign buffB_wr_en  = w_wr & r_sel_b;
    assign buff_wr_addr = w_wr ? r_cnt[9:0] : '0;
    assign buff_wr_data = w_wr ? mem_rd_data : '0;
    assign busy         = w_busy;
    // A loses when busy; B also loses when A triggers in the same cycle
    assign overrun      = (w_trig_a & w_busy) | (w_trig_b & (w_busy | w_trig_a));
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: directed bench for vga_line_fetch with a burst memory
// responder and a write monitor that checks every line-buffer write.
module tb_vga_line_fetch;
    localparam int BL = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        vga_mode = 1'b0;
    logic [23:0] fb_base = '0;
    logic        read_buffA_req = 1'b0;
    logic        read_buffB_req = 1'b0;
    logic [9:0]  read_buff_addr = '0;
    logic        mem_rd_req;
    logic [23:0] mem_rd_addr;
    logic        mem_rd_ack = 1'b0;
    logic        mem_rd_valid = 1'b0;
    logic [15:0] mem_rd_data = '0;
    logic        buffA_wr_en;
    logic        buffB_wr_en;
    logic [9:0]  buff_wr_addr;
    logic [15:0] buff_wr_data;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    vga_line_fetch #(.BURST_LEN(BL), .ADDR_W(24)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vga_mode(vga_mode), .fb_base(fb_base),
        .read_buffA_req(read_buffA_req), .read_buffB_req(read_buffB_req),
        .read_buff_addr(read_buff_addr), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .buffA_wr_en(buffA_wr_en), .buffB_wr_en(buffB_wr_en), .buff_wr_addr(buff_wr_addr),
        .buff_wr_data(buff_wr_data), .busy(busy), .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] mdata(input logic [23:0] a);
        return {a[7:0], a[15:8]} ^ {a[23:16], 8'h5A};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: one burst at a time, optional ack delay and valid gaps.
    int          rem = 0, widx = 0, ack_cnt = 0, ack_delay = 0, nb = 0;
    bit          gap_en = 0, ack_rand = 0, stray = 0;
    logic [23:0] burst_a = '0, first_a = '0, last_a = '0;
    always begin
        @(posedge sys_clk);
        #1;
        mem_rd_ack = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data = '0;
        if (!sys_rst_n) begin
            rem = 0;
            ack_cnt = 0;
        end else if (stray) begin
            mem_rd_valid = 1'b1;
            mem_rd_data = 16'hDEAD;
        end else if (rem > 0) begin
            if (!(gap_en && $urandom_range(0, 2) == 0)) begin
                mem_rd_valid = 1'b1;
                mem_rd_data = mdata(burst_a + 24'(widx));
                widx++;
                rem--;
            end
        end else if (mem_rd_req) begin
            if (ack_cnt < ack_delay) ack_cnt++;
            else begin
                mem_rd_ack = 1'b1;
                burst_a = mem_rd_addr;
                rem = BL;
                widx = 0;
                ack_cnt = 0;
                if (nb == 0) first_a = mem_rd_addr;
                last_a = mem_rd_addr;
                nb++;
                if (ack_rand) ack_delay = $urandom_range(0, 20);
            end
        end
    end

    // Write monitor: every write must be the next pixel of the expected line.
    bit          exp_b = 0;
    int          exp_idx = 0, wr_a = 0, wr_b = 0, n_ovr = 0;
    logic [23:0] exp_base = '0;
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (overrun) n_ovr++;
            if (mem_rd_req && rem > 0 && !mem_rd_ack) chk("req_while_outstanding", 1, 0);
            if (buffA_wr_en || buffB_wr_en) begin
                chk("wr_one_hot", {buffA_wr_en, buffB_wr_en} == 2'b11, 0);
                chk("wr_buffer_b", buffB_wr_en, exp_b);
                chk("wr_addr", buff_wr_addr, exp_idx[9:0]);
                chk("wr_data", buff_wr_data, mdata(exp_base + 24'(exp_idx)));
                chk("wr_no_req", mem_rd_req, 0);
                exp_idx++;
                if (buffA_wr_en) wr_a++;
                if (buffB_wr_en) wr_b++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic set_fetch(input bit b, input bit m, input logic [9:0] line, input logic [23:0] base);
        vga_mode = m;
        fb_base = base;
        read_buff_addr = line;
        exp_b = b;
        exp_idx = 0;
        exp_base = base + 24'(int'(line) * (m ? 1024 : 640));
        nb = 0;
    endtask

    task automatic wait_req(output int lat, input int bound);
        lat = 0;
        do begin
            @(negedge sys_clk);
            lat++;
        end while (!mem_rd_req && lat < bound);
        chk("req_rise_timeout", mem_rd_req, 1);
    endtask

    task automatic wait_busy_low(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge sys_clk);
            n++;
        end
        chk("busy_fall_timeout", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0, b0, o0, k;
        cyc(3);
        chk("rst_mem_rd_req", mem_rd_req, 0);
        chk("rst_mem_rd_addr", mem_rd_addr, 0);
        chk("rst_wr_en", {buffA_wr_en, buffB_wr_en}, 0);
        chk("rst_wr_addr", buff_wr_addr, 0);
        chk("rst_wr_data", buff_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        sys_rst_n = 1'b1;
        cyc(5);
        // Mode 0, buffer B, line 5, ack after 3 cycles
        ack_delay = 3;
        set_fetch(1, 0, 10'd5, 24'h001000);
        read_buffB_req = 1'b1;
        wait_req(lat, 20);
        chk("t1_latency_3_to_4", lat >= 3 && lat <= 4, 1);
        chk("t1_busy_high", busy, 1);
        chk("t1_first_addr_out", mem_rd_addr, 24'h001C80);
        wait_busy_low(5000);
        chk("t1_bursts", nb, 40);
        chk("t1_first_addr", first_a, 24'h001C80);
        chk("t1_last_addr", last_a, 24'h001EF0);
        chk("t1_wr_b", wr_b, 640);
        chk("t1_wr_a", wr_a, 0);
        chk("t1_idx_end", exp_idx, 640);
        chk("t1_no_overrun", n_ovr, 0);
        read_buffB_req = 1'b0;
        cyc(5);
        // Mode 1, buffer A, line 767, immediate ack
        ack_delay = 0;
        set_fetch(0, 1, 10'd767, 24'h000000);
        read_buffA_req = 1'b1;
        wait_busy_low(5);
        cyc(3);
        chk("t2_busy_high", busy, 1);
        wait_busy_low(5000);
        chk("t2_bursts", nb, 64);
        chk("t2_first_addr", first_a, 24'h0BFC00);
        chk("t2_last_addr", last_a, 24'h0BFFF0);
        chk("t2_wr_a", wr_a, 1024);
        chk("t2_idx_end", exp_idx, 1024);
        read_buffA_req = 1'b0;
        cyc(5);
        // B requested while A fetch is busy
        a0 = wr_a; b0 = wr_b; o0 = n_ovr;
        set_fetch(0, 0, 10'd2, 24'h002000);
        read_buffA_req = 1'b1;
        wait_req(lat, 20);
        read_buffB_req = 1'b1;
        cyc(5);
        chk("t3_overrun_pulse", n_ovr, o0 + 1);
        read_buffB_req = 1'b0;
        wait_busy_low(5000);
        chk("t3_bursts", nb, 40);
        chk("t3_first_addr", first_a, 24'h002500);
        chk("t3_wr_a", wr_a, a0 + 640);
        chk("t3_wr_b", wr_b, b0);
        read_buffA_req = 1'b0;
        cyc(5);
        // Simultaneous A and B in IDLE: A served, B dropped
        a0 = wr_a; b0 = wr_b; o0 = n_ovr;
        set_fetch(0, 0, 10'd1, 24'h000000);
        read_buffA_req = 1'b1;
        read_buffB_req = 1'b1;
        cyc(6);
        wait_busy_low(5000);
        chk("t4_overrun_pulse", n_ovr, o0 + 1);
        chk("t4_wr_a", wr_a, a0 + 640);
        chk("t4_wr_b", wr_b, b0);
        chk("t4_first_addr", first_a, 24'h000280);
        read_buffA_req = 1'b0;
        read_buffB_req = 1'b0;
        cyc(5);
        // Reset mid-burst, stray valid afterwards, held request must not retrigger
        set_fetch(1, 1, 10'd3, 24'h000400);
        read_buffB_req = 1'b1;
        k = 0;
        while (exp_idx < 20 && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        chk("t5_mid_fetch_reached", exp_idx >= 20, 1);
        sys_rst_n = 1'b0;
        #1;
        chk("t5_rst_req", mem_rd_req, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_wr_en", {buffA_wr_en, buffB_wr_en}, 0);
        chk("t5_rst_addr", mem_rd_addr, 0);
        cyc(3);
        a0 = wr_a; b0 = wr_b;
        sys_rst_n = 1'b1;
        stray = 1;
        cyc(10);
        stray = 0;
        cyc(20);
        chk("t5_no_wr_a", wr_a, a0);
        chk("t5_no_wr_b", wr_b, b0);
        chk("t5_held_no_busy", busy, 0);
        chk("t5_held_no_req", mem_rd_req, 0);
        read_buffB_req = 1'b0;
        cyc(5);
        set_fetch(1, 1, 10'd3, 24'h000400);
        read_buffB_req = 1'b1;
        wait_req(lat, 20);
        wait_busy_low(5000);
        chk("t5_refetch_wr_b", wr_b, b0 + 1024);
        chk("t5_refetch_first", first_a, 24'h001000);
        chk("t5_refetch_bursts", nb, 64);
        read_buffB_req = 1'b0;
        cyc(5);
        // Random valid gaps and ack delays, unaligned base, then address wrap
        gap_en = 1;
        ack_rand = 1;
        a0 = wr_a;
        set_fetch(0, 0, 10'd10, 24'h123456);
        read_buffA_req = 1'b1;
        wait_req(lat, 20);
        wait_busy_low(20000);
        chk("t6_bursts", nb, 40);
        chk("t6_first_addr", first_a, 24'h124D56);
        chk("t6_last_addr", last_a, 24'h124FC6);
        chk("t6_wr_a", wr_a, a0 + 640);
        read_buffA_req = 1'b0;
        cyc(5);
        a0 = wr_a;
        set_fetch(0, 1, 10'd1023, 24'hFF0000);
        read_buffA_req = 1'b1;
        wait_req(lat, 20);
        wait_busy_low(40000);
        chk("t7_bursts", nb, 64);
        chk("t7_first_addr_wrap", first_a, 24'h0EFC00);
        chk("t7_last_addr_wrap", last_a, 24'h0EFFF0);
        chk("t7_wr_a", wr_a, a0 + 1024);
        chk("t7_idx_end", exp_idx, 1024);
        read_buffA_req = 1'b0;
        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_line_fetch.md
VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, words returned per memory read burst (power of two, 4..64).
REQ-002 SHALL have parameter ADDR_W, default 24, memory word-address width.
REQ-003 sys_clk  in  1  single clock; all logic runs on its rising edge.
REQ-004 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 vga_mode  in  1  0 = 640-pixel lines, 1 = 1024-pixel lines; sampled only at fetch start.
REQ-006 fb_base  in  ADDR_W  framebuffer word base address; sampled only at fetch start.
REQ-007 read_buffA_req  in  1  level request from the display domain to fill line buffer A; asynchronous to sys_clk.
REQ-008 read_buffB_req  in  1  level request to fill line buffer B; asynchronous to sys_clk.
REQ-009 read_buff_addr  in  10  line number to fetch; stable while either request is high.
REQ-010 mem_rd_req  out  1  burst read request; held high until acknowledged.
REQ-011 mem_rd_addr  out  ADDR_W  burst start word address; held stable with mem_rd_req.
REQ-012 mem_rd_ack  in  1  one-cycle acceptance of mem_rd_req.
REQ-013 mem_rd_valid, mem_rd_data  in  1, 16  returned RGB565 word strobe and data; in order, BURST_LEN words per accepted burst.
REQ-014 buffA_wr_en, buffB_wr_en  out  1 each  line-buffer write enables.
REQ-015 buff_wr_addr, buff_wr_data  out  10, 16  line-buffer write pixel index and data.
REQ-016 busy  out  1  high from fetch start until the last word is written.
REQ-017 overrun  out  1  one-cycle pulse when a request is dropped.

Function
REQ-018 Each request input SHALL pass through a 2-flop synchronizer; a fetch SHALL trigger only on the synchronized rising edge.
REQ-019 read_buff_addr SHALL be captured on the trigger cycle without a synchronizer; it is stable by construction.
REQ-020 States SHALL be IDLE, REQ, DATA.
REQ-021 IDLE -> REQ on trigger: latch target buffer (A or B), line, LEN = 640 or 1024 per vga_mode, and base = fb_base + line*LEN.
REQ-022 line*LEN SHALL be formed by shifts (640 = <<9 + <<7; 1024 = <<10) and truncated to ADDR_W.
REQ-023 REQ: mem_rd_req=1, mem_rd_addr = base + word_cnt; on mem_rd_ack -> DATA.
REQ-024 DATA: each mem_rd_valid writes mem_rd_data at buff_wr_addr = word_cnt into the latched buffer in the same cycle, then increments word_cnt.
REQ-025 After BURST_LEN words: go to REQ if word_cnt < LEN; otherwise go to IDLE and drop busy.
REQ-026 Exactly one burst SHALL be outstanding; mem_rd_valid in IDLE or REQ SHALL be ignored.
REQ-027 A trigger while busy SHALL be dropped and pulse overrun; the current fetch SHALL continue unaffected.
REQ-028 Simultaneous A and B triggers in IDLE SHALL serve A and drop B (overrun pulse).
REQ-029 A request falling before completion SHALL NOT abort the fetch.
REQ-030 Write enables SHALL never both be high; buff_wr_addr SHALL never reach LEN.
REQ-031 Fill latency: mem_rd_req SHALL rise 1 cycle after the trigger cycle; the trigger occurs 2-3 sys_clk cycles after the raw request edge.

Reset
REQ-032 On reset: state IDLE; all outputs 0; word_cnt 0; synchronizers 0.
REQ-033 Reset mid-fetch SHALL abandon the burst immediately; words arriving after release SHALL be ignored.
REQ-034 A request already high at reset release SHALL NOT trigger until it falls and rises again.

Structure
REQ-035 Line lengths (640, 1024) and state encodings SHALL live in the shared vga package, alongside the display timing constants.
REQ-036 The 2-flop synchronizer SHALL be the sub-module sync2, instantiated once per request input.

Verification
REQ-037 Mode 0: fb_base=0x001000, B request, line 5, ack after 3 cycles -> 40 bursts; first address 0x001C80, last 0x001EF0; buffB receives indices 0..639 in order; busy then falls.
REQ-038 Mode 1: A request, line 767 -> 64 bursts from 0x0BFC00; buffA writes 0..1023.
REQ-039 B request raised while an A fetch is busy -> overrun pulse; the A fetch completes intact; no buffB writes.
REQ-040 Assert sys_rst_n low mid-burst, then inject stray mem_rd_valid after release -> no writes; outputs 0; a held request does not retrigger.
REQ-041 Random mem_rd_valid gaps and ack delays of 0..20 cycles -> data matches a memory model word-for-word; mem_rd_req is never high in DATA.
